// File: rtl/dbg_read_scheduler.sv
// dbg_read_scheduler: shares the debug read port between CPU reads and a debounced/auto-scanned viewer.
module dbg_read_scheduler #(
  parameter logic [19:0] DB_CYCLES      = 20'd500000,
  parameter logic [25:0] SCAN_PERIOD    = 26'd50000000,
  parameter logic [19:0] REFRESH_PERIOD = 20'd1000000,
  parameter logic [3:0]  STARVE_LIMIT   = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signal,
  input  logic [4:0]  address,
  input  logic        auto_en,
  input  logic        cpu_req,
  input  logic [4:0]  cpu_addr,
  output logic        cpu_gnt,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic        dbg_valid
);
  typedef enum logic [1:0] {IDLE, WAIT, READ, CAPTURE} state_t;
  state_t state;
  logic s1, s2, db_level, step, pending, tick, set_pending;
  logic [19:0] db_cnt, ref_cnt;
  logic [25:0] auto_cnt;
  logic [4:0] index, prev_target, rd_tag, target;
  logic [3:0] wait_cnt;
  assign tick = auto_en && auto_cnt == SCAN_PERIOD - 26'd1;
  assign target = address != 5'd0 ? address : index;
  assign set_pending = target != prev_target || ref_cnt == REFRESH_PERIOD - 20'd1;
  assign cpu_gnt = state != READ && cpu_req;
  assign rd_addr = state == READ ? target : cpu_addr;
  // a step fires only on the debounced rising edge, so a held button steps once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      db_level <= 1'b0;
      db_cnt <= '0;
      step <= 1'b0;
    end else begin
      s1 <= signal;
      s2 <= s1;
      step <= 1'b0;
      if (s2 == db_level) db_cnt <= '0;
      else if (db_cnt == DB_CYCLES - 20'd1) begin
        db_level <= s2;
        db_cnt <= '0;
        step <= s2;
      end else db_cnt <= db_cnt + 20'd1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      auto_cnt <= '0;
      index <= '0;
      prev_target <= '0;
      ref_cnt <= '0;
    end else begin
      auto_cnt <= (!auto_en || step || tick) ? '0 : auto_cnt + 26'd1;
      index <= address != 5'd0 ? 5'd0 : (step || tick) ? index + 5'd1 : index;
      prev_target <= target;
      ref_cnt <= (dbg_valid || ref_cnt == REFRESH_PERIOD - 20'd1) ? '0 : ref_cnt + 20'd1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pending <= 1'b1;
      wait_cnt <= '0;
      rd_tag <= '0;
      dbg_addr <= '0;
      dbg_data <= '0;
      dbg_valid <= 1'b0;
    end else begin
      dbg_valid <= 1'b0;
      pending <= pending | set_pending;
      case (state)
        IDLE: state <= pending ? WAIT : IDLE;
        WAIT:
          if (!cpu_req || wait_cnt == STARVE_LIMIT - 4'd1) state <= READ;
          else wait_cnt <= wait_cnt + 4'd1;
        READ: begin
          rd_tag <= target;
          pending <= set_pending;
          wait_cnt <= '0;
          state <= CAPTURE;
        end
        default: begin
          dbg_data <= rd_data;
          dbg_addr <= rd_tag;
          dbg_valid <= 1'b1;
          state <= (pending | set_pending) ? WAIT : IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_dbg_read_scheduler.sv
// tb_dbg_read_scheduler: directed bench with a scoreboard of expected viewer reads.
module tb_dbg_read_scheduler;
  logic clk = 1'b0, rst = 1'b1, signal = 1'b0, auto_en = 1'b0, cpu_req = 1'b0;
  logic [4:0] address = 5'd7, cpu_addr = 5'd3;
  logic cpu_gnt, dbg_valid;
  logic [4:0] rd_addr, dbg_addr;
  logic [31:0] rd_data = '0, dbg_data;
  logic [31:0] mem [32];
  logic [36:0] q [$];
  int checks = 0, failures = 0;

  dbg_read_scheduler #(
    .DB_CYCLES(20'd4), .SCAN_PERIOD(26'd10),
    .REFRESH_PERIOD(20'd1000000), .STARVE_LIMIT(4'd8)
  ) dut (
    .clk(clk), .rst(rst), .signal(signal), .address(address), .auto_en(auto_en),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt), .rd_addr(rd_addr),
    .rd_data(rd_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_valid(dbg_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && dbg_valid) begin
      if (q.size() == 0) check("unexpected_valid", {27'd0, dbg_addr}, 32'hFFFF_FFFF);
      else begin
        logic [36:0] e;
        e = q.pop_front();
        check("dbg_addr", {27'd0, dbg_addr}, {27'd0, e[36:32]});
        check("dbg_data", dbg_data, e[31:0]);
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a);
    q.push_back({a, mem[a]});
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && q.size() != 0; i++) tick();
    check("drain", q.size(), 0);
  endtask

  task automatic press();
    signal = 1'b1;
    repeat (10) tick();
    signal = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    repeat (2) tick();
    check("rst_valid", {31'd0, dbg_valid}, 0);
    check("rst_addr", {27'd0, dbg_addr}, 0);
    check("rst_data", dbg_data, 0);
    // reset release: IDLE->WAIT on first edge, READ after the second
    push(5'd7);
    rst = 1'b0;
    tick();
    tick();
    check("first_read_addr", {27'd0, rd_addr}, 32'd7);
    check("first_read_gnt", {31'd0, cpu_gnt}, 0);
    drain(10);
    address = 5'd0;
    push(5'd0);
    drain(20);
    for (int i = 1; i <= 3; i++) begin
      push(i[4:0]);
      press();
      drain(40);
    end
    signal = 1'b1;
    repeat (2) tick();
    signal = 1'b0;
    repeat (20) tick();
    check("glitch_no_step", {27'd0, dbg_addr}, 32'd3);
    for (int i = 4; i <= 31; i++) begin
      push(i[4:0]);
      press();
      drain(40);
    end
    push(5'd0);
    press();
    drain(40);
    check("wrap_addr", {27'd0, dbg_addr}, 32'd0);
    push(5'd1);
    press();
    drain(40);
    address = 5'd12;
    push(5'd12);
    drain(20);
    address = 5'd0;
    push(5'd0);
    drain(20);
    repeat (3) tick();
    // starvation: change at drive, pending after 1 edge, WAIT after 2, then 8 WAIT cycles
    cpu_req = 1'b1;
    cpu_addr = 5'd9;
    address = 5'd5;
    push(5'd5);
    n = 0;
    do begin
      tick();
      n++;
    end while (cpu_gnt && n < 30);
    check("starve_edges", n, 32'd10);
    check("starve_rd_addr", {27'd0, rd_addr}, 32'd5);
    tick();
    check("starve_gnt_back", {31'd0, cpu_gnt}, 1);
    check("starve_rd_cpu", {27'd0, rd_addr}, 32'd9);
    cpu_req = 1'b0;
    drain(20);
    address = 5'd0;
    push(5'd0);
    drain(20);
    repeat (3) tick();
    // auto ticks land after A9, A19, A29; the press step lands on the A19 tick
    push(5'd1);
    push(5'd2);
    push(5'd3);
    tick();
    auto_en = 1'b1;
    repeat (13) tick();
    signal = 1'b1;
    repeat (14) tick();
    signal = 1'b0;
    repeat (9) tick();
    auto_en = 1'b0;
    check("auto_seq_done", q.size(), 0);
    repeat (30) tick();
    check("auto_off_addr", {27'd0, dbg_addr}, 32'd3);
    address = 5'd20;
    n = 0;
    while (rd_addr != 5'd20 && n < 10) begin
      tick();
      n++;
    end
    check("rst_read_seen", {27'd0, rd_addr}, 32'd20);
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, dbg_valid}, 0);
    check("midrst_addr", {27'd0, dbg_addr}, 0);
    check("midrst_data", dbg_data, 0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_hold_valid", {31'd0, dbg_valid}, 0);
    push(5'd20);
    rst = 1'b0;
    drain(20);
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
